disp_demux: RTL and testbench
=============================

Name: disp_demux

Overview:
- Receive-side counterpart of the four-digit multiplexed 7-segment driver.
- Samples a time-multiplexed an/sseg bus, e.g. from a loopback header or another board, and rebuilds the four per-digit segment bytes.
- Flags complete scan frames, illegal anode patterns and a stalled scan.
- Used for board-to-board display mirroring and for self-check of the display path.

Parameters:
- SETTLE, 4: consecutive identical synchronized samples of {an,sseg} required before a capture; legal range 2..255.
- WD_W, 20: width of the watchdog counter; stale asserts after 2^WD_W-1 cycles without a frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- an  in  4  anode strobes, active-low one-cold; asynchronous to clk.
- sseg  in  8  segment byte, active-low (bit7 = dp); asynchronous to clk.
- err_clr  in  1  synchronous clear of err.
- out0, out1, out2, out3  out  8  captured segment byte for digits 0..3 (an 1110, 1101, 1011, 0111).
- digit_seen  out  4  per-digit captured-since-last-frame flags.
- frame_valid  out  1  one-cycle pulse when all four digits have been captured.
- err  out  1  sticky: a stable illegal anode pattern was seen.
- stale  out  1  no frame_valid for 2^WD_W-1 cycles.

Behaviour:
- Reset (reset=0, async):
  - out0..3 = 8'hFF (blank); digit_seen = 0; frame_valid = 0; err = 0; stale = 0.
  - Synchronizer flops = 12'hFFF; stability counter = 0; watchdog = 0.
- Synchronization: {an,sseg} passes through a 2-flop synchronizer (s), then one more register (p) for comparison.
- Stability counter cnt (8 b):
  - If s != p, cnt <= 0.
  - Else cnt <= cnt+1, saturating at SETTLE.
- Capture event: fires in the cycle where s == p and cnt == SETTLE-1, so exactly once per stable period. The response depends on s.an:
  - 1110/1101/1011/0111: out_k <= s.sseg and digit_seen[k] <= 1 on the next edge.
  - 1111: blanking interval, no action.
  - Any other pattern: err <= 1.
- Latency: a pin change held stable reaches out_k on the (SETTLE+3)-th rising edge after the first edge that samples it. Glitches shorter than SETTLE+1 cycles are never captured.
- Frame logic:
  - seen_next = digit_seen | capture mask.
  - If seen_next == 4'hF: digit_seen <= 0 and frame_valid <= 1 for one cycle. This holds even if the completing digit was already seen; digits may arrive in any order.
  - Duplicate captures of an already-seen digit overwrite out_k and do not advance the frame.
- err handling:
  - err clears when err_clr=1.
  - If err_clr and a new illegal capture occur in the same cycle, err stays 1 (set wins).
- Watchdog:
  - Increments every cycle, cleared on the cycle frame_valid is set.
  - Saturates at all-ones; stale <= 1 when it reaches all-ones.
  - stale clears together with the watchdog on the next frame.
- Outputs are registered, with no combinational path from inputs to outputs.
- Reset mid-frame discards partial digit_seen and all captured bytes.

Decomposition:
- Package disp_pkg holds:
  - typedef digit_idx_t (logic [1:0]).
  - Constants AN_D0..AN_D3 (4'b1110, 4'b1101, 4'b1011, 4'b0111) and AN_BLANK = 4'b1111.
  - Constant SSEG_BLANK = 8'hFF.
- disp_pkg is shared with the display driver.
- One sub-module, sync2 (parameter W, 2-flop synchronizer with async active-low reset to all-ones), instantiated with W=12.
- Anode decode, counter, capture, frame and watchdog logic stay in disp_demux.

Test Plan:
- Legal scan (SETTLE=4): drive an=1110/sseg=8'hC0, 1101/8'hF9, 1011/8'hA4, 0111/8'hB0, each for 20 cycles -> out0..3 = C0, F9, A4, B0; frame_valid pulses once, 1 cycle, after the 4th capture; digit_seen returns to 0.
- Glitch rejection: hold 1110/8'h99, insert 3-cycle 1110/8'h00 glitch -> out0 stays 99; 6-cycle hold of 8'h00 -> out0 = 00 on edge 7 after first sample.
- Illegal anode: hold an=1100 for 10 cycles -> err=1, no out change; err_clr pulse -> err=0; err_clr coincident with a fresh illegal capture -> err stays 1.
- Out-of-order/duplicate: digits 2, 0, 0 (new value 8'h92), 3, 1 -> single frame_valid after digit 1; out0 = 92.
- Watchdog (WD_W=6): no anode activity for 70 cycles -> stale=1 at cycle 63; one full scan -> stale=0 with frame_valid.
- Reset mid-frame: capture digits 0 and 1, pull reset low one cycle -> all outs FF, digit_seen=0, err=0, stale=0 asynchronously; next full scan yields a normal frame.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display path
// (driver and receive-side demultiplexer).
package disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_D0    = 4'b1110;
  localparam logic [3:0] AN_D1    = 4'b1101;
  localparam logic [3:0] AN_D2    = 4'b1011;
  localparam logic [3:0] AN_D3    = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  // One sample of the display bus as it appears on the pins.
  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
  } bus_t;

endpackage

// File: rtl/disp_demux_sync2.sv
// Two-flop synchronizer; both stages reset to all-ones so a reset bus
// looks like a blanked display (all strobes and segments inactive).
module sync2 #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/disp_demux.sv
// Receive side of a four-digit multiplexed 7-segment bus: rebuilds the
// per-digit segment bytes and flags frames, illegal strobes and a dead scan.
module disp_demux
  import disp_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int WD_W   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  input  logic       err_clr,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic [3:0] digit_seen,
  output logic       frame_valid,
  output logic       err,
  output logic       stale
);

  localparam logic [7:0]      CNT_SAT = 8'(SETTLE);
  localparam logic [7:0]      CNT_CAP = 8'(SETTLE - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

  bus_t       s_bus;
  bus_t       p_bus;
  logic [7:0] cnt;
  logic       capture;
  logic [3:0] cap_mask;
  digit_idx_t cap_idx;
  logic       cap_illegal;
  logic [3:0] seen_next;
  logic       frame_done;
  logic [7:0] out_r [4];
  logic [WD_W-1:0] wd;

  sync2 #(.W($bits(bus_t))) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({an, sseg}),
    .q     (s_bus)
  );

  // Stability counter: saturates so a long-held pattern captures only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_bus <= '1;
      cnt   <= '0;
    end else begin
      p_bus <= s_bus;
      if (s_bus != p_bus) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign capture = (s_bus == p_bus) && (cnt == CNT_CAP);

  always_comb begin
    cap_mask    = '0;
    cap_idx     = '0;
    cap_illegal = 1'b0;
    if (capture) begin
      case (s_bus.an)
        AN_D0:    begin cap_mask = 4'b0001; cap_idx = 2'd0; end
        AN_D1:    begin cap_mask = 4'b0010; cap_idx = 2'd1; end
        AN_D2:    begin cap_mask = 4'b0100; cap_idx = 2'd2; end
        AN_D3:    begin cap_mask = 4'b1000; cap_idx = 2'd3; end
        AN_BLANK: ;
        default:  cap_illegal = 1'b1;
      endcase
    end
  end

  assign seen_next  = digit_seen | cap_mask;
  assign frame_done = &seen_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) out_r[i] <= SSEG_BLANK;
    end else if (|cap_mask) begin
      out_r[cap_idx] <= s_bus.sseg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_seen  <= '0;
      frame_valid <= 1'b0;
    end else if (frame_done) begin
      digit_seen  <= '0;
      frame_valid <= 1'b1;
    end else begin
      digit_seen  <= seen_next;
      frame_valid <= 1'b0;
    end
  end

  // A new illegal capture takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (cap_illegal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd    <= '0;
      stale <= 1'b0;
    end else if (frame_done) begin
      wd    <= '0;
      stale <= 1'b0;
    end else if (wd != WD_MAX) begin
      wd <= wd + WD_ONE;
      if (wd == WD_MAX - WD_ONE) stale <= 1'b1;
    end
  end

  assign out0 = out_r[0];
  assign out1 = out_r[1];
  assign out2 = out_r[2];
  assign out3 = out_r[3];

endmodule

// File: tb/tb_disp_demux.sv
// Bench for disp_demux: directed scenarios plus a randomized scan, checked
// every cycle against a pin-history model of the receiver.
module tb_disp_demux;
  import disp_pkg::*;

  localparam int SETTLE = 4;
  localparam int WD_W   = 6;
  localparam int WD_MAX = (1 << WD_W) - 1;
  localparam logic [3:0] AN_TAB [4] = '{AN_D0, AN_D1, AN_D2, AN_D3};

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] an      = 4'hF;
  logic [7:0] sseg    = 8'hFF;
  logic       err_clr = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] digit_seen;
  logic       frame_valid, err, stale;

  disp_demux #(.SETTLE(SETTLE), .WD_W(WD_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .err_clr     (err_clr),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .digit_seen  (digit_seen),
    .frame_valid (frame_valid),
    .err         (err),
    .stale       (stale)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_fail   = 0;
  int fv_count = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A value is captured once it has been on the pins for SETTLE+1
  // consecutive sampling edges; the sync pipeline delays its effect by two.
  logic [11:0] hist [$];
  logic [7:0]  m_out [4];
  logic [3:0]  m_seen;
  logic        m_fv, m_err, m_stale;
  int          m_since;

  function automatic void model_reset();
    hist = {};
    repeat (3) hist.push_back(12'hFFF);
    for (int k = 0; k < 4; k++) m_out[k] = 8'hFF;
    m_seen  = '0;
    m_fv    = 1'b0;
    m_err   = 1'b0;
    m_stale = 1'b0;
    m_since = 0;
  endfunction

  function automatic void model_step(input logic [11:0] x, input logic clr);
    int idx, run;
    logic [11:0] v;
    logic illegal;
    hist.push_back(x);
    if (hist.size() > 64) void'(hist.pop_front());
    idx = hist.size() - 3;
    v   = hist[idx];
    run = 0;
    for (int k = idx; k >= 0; k--) begin
      if (hist[k] != v || run >= SETTLE + 2) break;
      run++;
    end
    illegal = 1'b0;
    m_fv    = 1'b0;
    if (run == SETTLE + 1) begin
      if (v[11:8] != AN_BLANK) illegal = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (v[11:8] == AN_TAB[k]) begin
          m_out[k]  = v[7:0];
          m_seen[k] = 1'b1;
          illegal   = 1'b0;
        end
      end
    end
    if (m_seen == 4'hF) begin
      m_seen = '0;
      m_fv   = 1'b1;
    end
    if (illegal) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (m_fv) m_since = 0;
    else m_since++;
    m_stale = (m_since >= WD_MAX);
  endfunction

  always @(posedge clk) if (reset) model_step({an, sseg}, err_clr);

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("out0", out0, m_out[0]);
      check("out1", out1, m_out[1]);
      check("out2", out2, m_out[2]);
      check("out3", out3, m_out[3]);
      check("digit_seen", digit_seen, m_seen);
      check("frame_valid", frame_valid, m_fv);
      check("err", err, m_err);
      check("stale", stale, m_stale);
      if (frame_valid) fv_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    an   = 4'hF;
    sseg = 8'hFF;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("rst_out0", out0, 8'hFF);
    check("rst_out1", out1, 8'hFF);
    check("rst_out2", out2, 8'hFF);
    check("rst_out3", out3, 8'hFF);
    check("rst_seen", digit_seen, 4'h0);
    check("rst_fv", frame_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_stale", stale, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic full_scan(input int n);
    hold(AN_D0, 8'hC0, n);
    hold(AN_D1, 8'hF9, n);
    hold(AN_D2, 8'hA4, n);
    hold(AN_D3, 8'hB0, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int fv0;
    logic [3:0] a;
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("init_out0", out0, 8'hFF);
    check("init_seen", digit_seen, 4'h0);
    check("init_err", err, 1'b0);
    check("init_stale", stale, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    // Watchdog with an idle bus: stale rises on exactly edge 63.
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      if (i == 62) check("wd_stale_62", stale, 1'b0);
      if (i == 63) check("wd_stale_63", stale, 1'b1);
    end
    @(negedge clk);

    // Legal scan.
    fv0 = fv_count;
    full_scan(20);
    check("scan_out0", out0, 8'hC0);
    check("scan_out1", out1, 8'hF9);
    check("scan_out2", out2, 8'hA4);
    check("scan_out3", out3, 8'hB0);
    check("scan_frames", fv_count - fv0, 1);
    check("scan_seen", digit_seen, 4'h0);
    check("scan_stale", stale, 1'b0);

    // Glitch rejection and capture latency.
    hold(AN_D0, 8'h99, 20);
    hold(AN_D0, 8'h00, 3);
    hold(AN_D0, 8'h99, 20);
    check("glitch_out0", out0, 8'h99);
    an   = AN_D0;
    sseg = 8'h00;
    repeat (6) @(posedge clk);
    #1 check("lat_edge6", out0, 8'h99);
    @(posedge clk);
    #1 check("lat_edge7", out0, 8'h00);
    @(negedge clk);
    hold(AN_D0, 8'h00, 5);

    // Illegal anode, clear, and clear colliding with a fresh error.
    hold(4'b1100, 8'h55, 10);
    check("ill_err", err, 1'b1);
    check("ill_out0", out0, 8'h00);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", err, 1'b0);
    an   = 4'b0011;
    sseg = 8'h12;
    repeat (6) @(posedge clk);
    #1 check("coll_pre", err, 1'b0);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1 check("coll_err", err, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    hold(4'b0011, 8'h12, 3);

    // Out-of-order and duplicate digits.
    do_reset();
    fv0 = fv_count;
    hold(AN_D2, 8'hA4, 12);
    hold(AN_D0, 8'hC0, 12);
    hold(AN_D0, 8'h92, 12);
    hold(AN_D3, 8'hB0, 12);
    check("ooo_no_frame", fv_count - fv0, 0);
    hold(AN_D1, 8'hF9, 12);
    check("ooo_frame", fv_count - fv0, 1);
    check("ooo_out0", out0, 8'h92);

    // Reset in the middle of a frame.
    hold(4'b1000, 8'h00, 10);
    hold(AN_D0, 8'h81, 12);
    hold(AN_D1, 8'h82, 12);
    check("mid_err", err, 1'b1);
    check("mid_seen", digit_seen, 4'b0011);
    do_reset();
    fv0 = fv_count;
    full_scan(12);
    check("post_rst_frame", fv_count - fv0, 1);

    // Randomized scan traffic, glitches, blanking and illegal strobes.
    for (int it = 0; it < 250; it++) begin
      int r, n;
      r = $urandom_range(0, 9);
      if (r <= 6) a = AN_TAB[$urandom_range(0, 3)];
      else if (r <= 8) a = AN_BLANK;
      else begin
        do a = 4'($urandom_range(0, 15));
        while (a == AN_D0 || a == AN_D1 || a == AN_D2 || a == AN_D3 || a == AN_BLANK);
      end
      an   = a;
      sseg = 8'($urandom);
      n    = $urandom_range(1, 12);
      for (int c = 0; c < n; c++) begin
        err_clr = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
    end
    err_clr = 1'b0;
    hold(AN_BLANK, 8'hFF, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
